feedback_window_sequencer: RTL
==============================

Name: feedback_window_sequencer

Overview:
- Controls the motor-feedback position manager. It issues the clear pulses, times a measurement window, and snapshots the window position counts, difference and elapsed cycles.
- Presents each snapshot to a register-interface consumer through a valid/ready handshake.
- Supports single-shot and continuous back-to-back windows.

Parameters:
- CNT_W, 32, width of the window-length counter and the snap_cycles field.
- POS_W, 16, width of the position and difference fields.
- SETTLE_CYCLES, 2, idle cycles after a clear, covering the position manager's 2-stage sensor synchroniser.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a measurement
- stop  in  1  single-cycle pulse; aborts the measurement
- continuous  in  1  1 = re-arm automatically after each capture; sampled at start
- window_len  in  CNT_W  window length in clk cycles; sampled at start
- clear  out  2  to position manager; bit0 clears the cycle counter, bit1 clears the window position counters
- pos1_in  in  POS_W  window count, motor 1
- pos2_in  in  POS_W  window count, motor 2
- diff_in  in  POS_W  pos1 − pos2 (wrapped)
- cycles_in  in  CNT_W  elapsed-cycle counter
- snap_pos1, snap_pos2, snap_diff  out  POS_W  captured values
- snap_cycles  out  CNT_W  captured cycle count
- snap_valid  out  1  snapshot available
- snap_ready  in  1  consumer accepts the snapshot
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky; a capture was dropped
- saturated  out  1  sticky; bit POS_W−1 of pos1_in or pos2_in was set at a capture

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, including clear=2'b00, snap_*=0, snap_valid=0, overrun=0, saturated=0. Reset mid-window abandons the window; nothing is captured.
- FSM states:
  - IDLE: start → CLEAR. On that transition, latch len = max(window_len, 1) and the continuous bit; clear overrun and saturated.
  - CLEAR: clear=2'b11 for exactly 1 cycle → SETTLE.
  - SETTLE: clear=00 for SETTLE_CYCLES cycles → WINDOW.
  - WINDOW: down-counter loaded with len; decrement each cycle; when it reaches 1 → CAPTURE.
  - CAPTURE: 1 cycle. Evaluate the capture rule below. Then → CLEAR if continuous, else → IDLE.
- Capture rule:
  - If snap_valid=0, or snap_valid&snap_ready in this same cycle: latch all inputs into snap_* and set snap_valid on the next cycle.
  - Otherwise keep the old snapshot and set overrun. The snapshot is never overwritten while pending.
  - Set saturated if bit POS_W−1 of pos1_in or pos2_in is 1.
- Handshake: snap_valid clears the cycle after snap_valid&snap_ready. snap_valid stays asserted across stop and start; only rst clears it.
- Latency: start at cycle 0 → CLEAR at cycle 1 → capture at cycle 1 + 1 + SETTLE_CYCLES + len. With defaults, len=N gives snap_valid high at cycle N+5.
- stop in any non-IDLE state → IDLE next cycle; clear=00; no capture. stop in the CAPTURE cycle wins: no capture.
- start while busy is ignored. stop and start in the same IDLE cycle: start wins.
- busy = (state != IDLE).
- Windows are gapless except for the CLEAR and SETTLE overhead of 1+SETTLE_CYCLES cycles per window.

Optional Feature:
- Macro: FEEDBACK_DRIFT_ACCUM_EN.
- Enabled:
  - Adds output drift_acc (32 bits).
  - At each CAPTURE, diff_in is sign-extended and added to drift_acc, whether or not the snapshot is dropped.
  - drift_acc saturates at ±(2^31−1) instead of wrapping.
  - Cleared by rst and by start from IDLE.
- Disabled: the port and the logic are absent.

Decomposition:
- Shared package (feedback_pkg) holds:
  - the state enum: IDLE, CLEAR, SETTLE, WINDOW, CAPTURE;
  - clear encodings: CLR_NONE=2'b00, CLR_CYC=2'b01, CLR_POS=2'b10, CLR_ALL=2'b11;
  - the SETTLE_CYCLES default.
- One sub-module: feedback_snapshot_reg. It holds the snapshot registers and valid/ready/overrun logic, with a single "capture" strobe from the FSM.

Test Plan:
- rst, then start with window_len=10, continuous=0 → clear=11 for 1 cycle at cycle 1; snap_valid at cycle 15; busy drops the cycle after CAPTURE. Drive 4 position edges → snap_pos1=4, snap_cycles≈13.
- window_len=0 → treated as 1; snap_valid at cycle 6.
- continuous=1, window_len=8, snap_ready held 0 → first snapshot held; second capture sets overrun=1 and snap_pos1 is unchanged. Pulse snap_ready → next capture is accepted.
- stop asserted mid-WINDOW → IDLE next cycle, no snap_valid, clear=00. Then start → normal capture; overrun=0.
- pos1_in=16'h8001 at capture → saturated=1, sticky until the next start. Assert rst mid-WINDOW → all outputs 0 the next cycle.
- With FEEDBACK_DRIFT_ACCUM_EN: diff_in=−3 across 3 windows → drift_acc=−9. Preload near 2^31−1 with diff_in=+100 → drift_acc clamps at 32'h7FFF_FFFF.

Source files
------------

// File: rtl/feedback_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | feedback_pkg : shared types and constants for the window sequencer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package feedback_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      SETTLE  = 3'd2,
      WINDOW  = 3'd3,
      CAPTURE = 3'd4
   } state_t;

   localparam logic [1:0] CLR_NONE = 2'b00;
   localparam logic [1:0] CLR_CYC  = 2'b01;
   localparam logic [1:0] CLR_POS  = 2'b10;
   localparam logic [1:0] CLR_ALL  = 2'b11;

   localparam int SETTLE_CYCLES_DEF = 2;

   // Signed add clamped symmetrically to +/-(2^31-1).
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {a[31], a} + {b[31], b};
      if (!s[32] && s[31])
         return 32'h7FFF_FFFF;
      if (s[32] && (!s[31] || (s[31:0] == 32'h8000_0000)))
         return 32'h8000_0001;
      return s[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/feedback_window_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | feedback_window_sequencer_if : snapshot valid/ready bus            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface feedback_window_sequencer_if #(
   parameter int CNT_W = 32,
   parameter int POS_W = 16
);
   logic [POS_W-1:0] snap_pos1;
   logic [POS_W-1:0] snap_pos2;
   logic [POS_W-1:0] snap_diff;
   logic [CNT_W-1:0] snap_cycles;
   logic             snap_valid;
   logic             snap_ready;

   modport master (
      output snap_pos1, snap_pos2, snap_diff, snap_cycles, snap_valid,
      input  snap_ready
   );

   modport slave (
      input  snap_pos1, snap_pos2, snap_diff, snap_cycles, snap_valid,
      output snap_ready
   );
endinterface
`default_nettype wire

// File: rtl/feedback_snapshot_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | feedback_snapshot_reg : snapshot holding regs, handshake, stickies |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module feedback_snapshot_reg #(
   parameter int CNT_W = 32,
   parameter int POS_W = 16
) (
   input  wire              clk,
   input  wire              rst,
   input  wire              i_capture,
   input  wire              i_clr_sticky,
   input  wire [POS_W-1:0]  i_pos1,
   input  wire [POS_W-1:0]  i_pos2,
   input  wire [POS_W-1:0]  i_diff,
   input  wire [CNT_W-1:0]  i_cycles,
   output logic             o_overrun,
   output logic             o_saturated,
   feedback_window_sequencer_if.master snap
);

   // A pending snapshot is only replaced when it is consumed in the capture cycle.
   logic w_take;
   assign w_take = i_capture && (!snap.snap_valid || snap.snap_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         snap.snap_pos1   <= '0;
         snap.snap_pos2   <= '0;
         snap.snap_diff   <= '0;
         snap.snap_cycles <= '0;
         snap.snap_valid  <= 1'b0;
         o_overrun        <= 1'b0;
         o_saturated      <= 1'b0;
      end else begin
         if (w_take) begin
            snap.snap_pos1   <= i_pos1;
            snap.snap_pos2   <= i_pos2;
            snap.snap_diff   <= i_diff;
            snap.snap_cycles <= i_cycles;
            snap.snap_valid  <= 1'b1;
         end else if (snap.snap_valid && snap.snap_ready) begin
            snap.snap_valid  <= 1'b0;
         end

         if (i_clr_sticky) begin
            o_overrun   <= 1'b0;
            o_saturated <= 1'b0;
         end else if (i_capture) begin
            if (!w_take)
               o_overrun <= 1'b1;
            if (i_pos1[POS_W-1] || i_pos2[POS_W-1])
               o_saturated <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/feedback_window_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | feedback_window_sequencer : clear / settle / window / capture FSM  |
// | Optional drift accumulator: FEEDBACK_DRIFT_ACCUM_EN   Rev 1.0      |
// +--------------------------------------------------------------------+
module feedback_window_sequencer
   import feedback_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter int POS_W         = 16,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  wire              clk,
   input  wire              rst,
   input  wire              i_start,
   input  wire              i_stop,
   input  wire              i_continuous,
   input  wire [CNT_W-1:0]  i_window_len,
   output logic [1:0]       o_clear,
   input  wire [POS_W-1:0]  i_pos1_in,
   input  wire [POS_W-1:0]  i_pos2_in,
   input  wire [POS_W-1:0]  i_diff_in,
   input  wire [CNT_W-1:0]  i_cycles_in,
   output logic             o_busy,
   output logic             o_overrun,
   output logic             o_saturated,
`ifdef FEEDBACK_DRIFT_ACCUM_EN
   output logic [31:0]      o_drift_acc,
`endif
   feedback_window_sequencer_if.master snap
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_len;
   logic             r_cont;
   logic             w_start_idle;
   logic             w_capture;

   assign w_start_idle = (r_state == IDLE) && i_start;

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next = CLEAR;
         CLEAR:   w_next = (SETTLE_CYCLES == 0) ? WINDOW : SETTLE;
         SETTLE:  if (r_cnt == CNT_W'(1)) w_next = WINDOW;
         WINDOW:  if (r_cnt == CNT_W'(1)) w_next = CAPTURE;
         CAPTURE: w_next = r_cont ? CLEAR : IDLE;
         default: w_next = IDLE;
      endcase
      if ((r_state != IDLE) && i_stop)
         w_next = IDLE;
   end

   always_comb begin
      o_clear   = CLR_NONE;
      o_busy    = (r_state != IDLE);
      w_capture = (r_state == CAPTURE) && !i_stop;
      if (r_state == CLEAR)
         o_clear = CLR_ALL;
   end

   // One down-counter serves both the settle delay and the window length.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_len  <= '0;
         r_cont <= 1'b0;
      end else begin
         if (w_start_idle) begin
            r_len  <= (i_window_len == '0) ? CNT_W'(1) : i_window_len;
            r_cont <= i_continuous;
         end
         case (r_state)
            CLEAR:   r_cnt <= (SETTLE_CYCLES == 0) ? r_len : CNT_W'(SETTLE_CYCLES);
            SETTLE:  r_cnt <= (r_cnt == CNT_W'(1)) ? r_len : r_cnt - CNT_W'(1);
            WINDOW:  r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   feedback_snapshot_reg #(
      .CNT_W (CNT_W),
      .POS_W (POS_W)
   ) u_snapshot (
      .clk          (clk),
      .rst          (rst),
      .i_capture    (w_capture),
      .i_clr_sticky (w_start_idle),
      .i_pos1       (i_pos1_in),
      .i_pos2       (i_pos2_in),
      .i_diff       (i_diff_in),
      .i_cycles     (i_cycles_in),
      .o_overrun    (o_overrun),
      .o_saturated  (o_saturated),
      .snap         (snap)
   );

`ifdef FEEDBACK_DRIFT_ACCUM_EN
   logic [31:0] r_drift_acc;

   always_ff @(posedge clk) begin
      if (rst || w_start_idle)
         r_drift_acc <= '0;
      else if (w_capture)
         r_drift_acc <= sat_add32(r_drift_acc, {{(32-POS_W){i_diff_in[POS_W-1]}}, i_diff_in});
   end

   assign o_drift_acc = r_drift_acc;
`endif

endmodule
`default_nettype wire
